seg_memory: RTL and testbench
=============================

// Module: seg_memory
// PURPOSE
// - MEM stage of the 5-stage MIPS pipeline; consumes seg_execute outputs (ALU result, store data, dest reg, WB/MEM ctrl buses).
// - Owns the data memory (sync read/write, byte/half/word, signed/unsigned loads), resolves branch taken, holds the MEM/WB register.
// - Feeds the EX/MEM forwarding value back to seg_execute (i_rd_mem_forwarding).
// PARAMETERS
// - LEN          32  datapath width
// - NB_ADDR      5   register-file address width
// - NB_CTRL_WB   2   WB bus width: [1] RegWrite, [0] MemtoReg
// - NB_CTRL_M    9   MEM bus: [8] MemRead [7] MemWrite [6] BranchEQ [5] BranchNE [4:3] size (00 B,01 H,11 W; 10 = W) [2] LoadUnsigned [1:0] reserved (ignored)
// - NB_DMEM_ADDR 10  data-memory word-address width (2^NB_DMEM_ADDR words of LEN bits)
// PORTS
// - i_clk            in   1             clock
// - i_rst            in   1             synchronous reset, active-high
// - i_enable         in   1             pipeline advance (debug step); 0 = hold all state, suppress writes
// - i_PC_branch      in   LEN           branch target from EX
// - i_ALU_result     in   LEN           byte address / ALU value
// - i_write_data     in   LEN           store data (rt)
// - i_write_register in   NB_ADDR       destination register
// - i_ALU_zero       in   1             ALU zero flag
// - i_ctrl_wb_bus    in   NB_CTRL_WB    WB control
// - i_ctrl_mem_bus   in   NB_CTRL_M     MEM control
// - o_PC_branch      out  LEN           = i_PC_branch (comb)
// - o_PC_src         out  1             branch taken (comb)
// - o_rd_mem_forward out  LEN           = i_ALU_result (comb), to EX forwarding mux 01
// - o_read_data      out  LEN           loaded data, extended (registered)
// - o_ALU_result     out  LEN           MEM/WB copy of i_ALU_result
// - o_write_register out  NB_ADDR       MEM/WB copy
// - o_ctrl_wb_bus    out  NB_CTRL_WB    MEM/WB copy
// - o_misaligned     out  1             registered 1-cycle flag for misaligned access
// - i_dbg_addr       in   NB_DMEM_ADDR  debug word address
// - o_dbg_data       out  LEN           debug read data
// BEHAVIOUR
// - Reset (posedge, i_rst=1): all registered outputs 0; memory contents untouched; reset wins over i_enable.
// - Word index = i_ALU_result[NB_DMEM_ADDR+1:2]; upper address bits ignored (wrap-around).
// - Store (MemWrite & i_enable & aligned): written at posedge; B: lane addr[1:0], data[7:0]; H: lane addr[1], data[15:0]; W: all 4 bytes. Little-endian lanes (byte 0 = bits 7:0).
// - Load (MemRead): word read sync; lane selected and extended into o_read_data, 1-cycle latency, aligned with other MEM/WB outputs.
//   Sign-extend unless LoadUnsigned; W ignores LoadUnsigned.
// - Not MemRead: o_read_data <= 0.
// - Misaligned: H with addr[0]=1, W with addr[1:0]!=0 -> no write, o_read_data <= 0, o_misaligned <= 1 for that cycle.
// - MemRead & MemWrite both 1: write performed, o_read_data <= 0.
// - o_PC_src = (BranchEQ & i_ALU_zero) | (BranchNE & ~i_ALU_zero); independent of i_enable.
// - i_enable=0: MEM/WB regs, o_read_data, o_misaligned hold; no memory write.
// - Latency: inputs -> MEM/WB outputs exactly 1 cycle when i_enable=1.
// CONFIGURATION
// - MEM_DEBUG_PORT_EN defined: o_dbg_data <= mem[i_dbg_addr] every posedge (1-cycle latency, ignores i_enable, 0 on reset); second read port, never writes.
// - Not defined: o_dbg_data tied 0, i_dbg_addr unused; no second read port inferred.
// TESTING
// - SW 0xDEADBEEF @0x10, next cycle LW @0x10 -> o_read_data=0xDEADBEEF one cycle after load.
// - Mem[0x4]=0, SB 0x80 @0x5; LB @0x5 -> 0xFFFFFF80; LBU @0x5 -> 0x00000080; LW @0x4 -> 0x00008000.
// - SH 0xABCD @0x6 -> LW @0x4 =0xABCD0000; LH @0x6 -> 0xFFFFABCD; SW @0x2 -> no write, o_misaligned=1 one cycle, LW @0x0 unchanged.
// - BranchEQ, zero=1 -> o_PC_src=1, o_PC_branch=i_PC_branch; BranchNE, zero=1 -> o_PC_src=0.
// - i_enable=0 with SW pending -> memory unchanged, outputs hold; i_rst=1 mid-load -> all registered outputs 0 next cycle, mem kept.
// - MEM_DEBUG_PORT_EN: after SW 0x12345678 @0x20, i_dbg_addr=8 -> o_dbg_data=0x12345678 next cycle; undefined -> always 0.

Source files
------------

// File: rtl/seg_memory.sv
// -----------------------------------------------------------------------------
// seg_memory -- MEM stage of the 5-stage MIPS pipeline.
//
// Owns the data memory (synchronous read/write, byte/half/word accesses,
// signed/unsigned loads), resolves whether a branch is taken, and holds the
// MEM/WB pipeline register. The EX/MEM ALU value is fed straight back to the
// execute stage for forwarding.
//
// Build option:
//   MEM_DEBUG_PORT_EN  when defined, adds a second (read-only) memory port:
//                      o_dbg_data <= mem[i_dbg_addr] every clock, 0 on reset.
//                      When undefined, o_dbg_data is tied 0 and i_dbg_addr
//                      is unused.
//
// Flow control: there is no valid/ready pair. i_enable is the single advance
// strobe: when 1, every registered output captures the current inputs on the
// rising edge and a store may write memory; when 0, all pipeline state holds
// and memory is not written. Reset overrides i_enable.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_enable            pipeline advance (debug step)
//   i_PC_branch         branch target from EX          -> o_PC_branch (comb)
//   i_ALU_result        byte address / ALU value        -> o_rd_mem_forward (comb)
//   i_write_data        store data (rt)
//   i_write_register    destination register
//   i_ALU_zero          ALU zero flag
//   i_ctrl_wb_bus       [1] RegWrite [0] MemtoReg
//   i_ctrl_mem_bus      [8] MemRead [7] MemWrite [6] BranchEQ [5] BranchNE
//                       [4:3] size (00 B, 01 H, 1x W) [2] LoadUnsigned
//                       [1:0] reserved
//   o_PC_src            branch taken (comb)
//   o_read_data         loaded data, extended, aligned with MEM/WB outputs
//   o_ALU_result, o_write_register, o_ctrl_wb_bus   MEM/WB register copies
//   o_misaligned        1-cycle flag for a misaligned access
//   i_dbg_addr, o_dbg_data   debug word read port
//
// The lane logic assumes LEN = 32 (four byte lanes).
// -----------------------------------------------------------------------------
module seg_memory #(
    parameter int LEN          = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_CTRL_WB   = 2,
    parameter int NB_CTRL_M    = 9,
    parameter int NB_DMEM_ADDR = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic [LEN-1:0]          i_PC_branch,
    input  logic [LEN-1:0]          i_ALU_result,
    input  logic [LEN-1:0]          i_write_data,
    input  logic [NB_ADDR-1:0]      i_write_register,
    input  logic                    i_ALU_zero,
    input  logic [NB_CTRL_WB-1:0]   i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]    i_ctrl_mem_bus,
    output logic [LEN-1:0]          o_PC_branch,
    output logic                    o_PC_src,
    output logic [LEN-1:0]          o_rd_mem_forward,
    output logic [LEN-1:0]          o_read_data,
    output logic [LEN-1:0]          o_ALU_result,
    output logic [NB_ADDR-1:0]      o_write_register,
    output logic [NB_CTRL_WB-1:0]   o_ctrl_wb_bus,
    output logic                    o_misaligned,
    input  logic [NB_DMEM_ADDR-1:0] i_dbg_addr,
    output logic [LEN-1:0]          o_dbg_data
);

    localparam int MEM_WORDS = 2 ** NB_DMEM_ADDR;

    logic [LEN-1:0] mem [0:MEM_WORDS-1];

    // Control decode
    logic       mem_read;
    logic       mem_write;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] acc_size;
    logic       load_unsigned;

    assign mem_read      = i_ctrl_mem_bus[8];
    assign mem_write     = i_ctrl_mem_bus[7];
    assign branch_eq     = i_ctrl_mem_bus[6];
    assign branch_ne     = i_ctrl_mem_bus[5];
    assign acc_size      = i_ctrl_mem_bus[4:3];
    assign load_unsigned = i_ctrl_mem_bus[2];

    // Combinational pass-throughs
    assign o_PC_branch      = i_PC_branch;
    assign o_rd_mem_forward = i_ALU_result;
    assign o_PC_src         = (branch_eq & i_ALU_zero) | (branch_ne & ~i_ALU_zero);

    // Address decode: upper address bits are dropped, so accesses wrap.
    logic [NB_DMEM_ADDR-1:0] word_idx;
    logic [1:0]              byte_off;
    logic                    is_half;
    logic                    is_word;
    logic                    misaligned;
    logic                    mem_we;

    assign word_idx = i_ALU_result[NB_DMEM_ADDR+1:2];
    assign byte_off = i_ALU_result[1:0];
    assign is_half  = (acc_size == 2'b01);
    assign is_word  = acc_size[1];  // 10 is treated as a word access

    // Only an actual memory access can be misaligned; plain ALU ops never flag.
    assign misaligned = (mem_read | mem_write) &
                        ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));

    assign mem_we = ~i_rst & i_enable & mem_write & ~misaligned;

    // Byte enables and lane-replicated store data (little-endian lanes).
    logic [3:0]     byte_en;
    logic [LEN-1:0] wr_word;

    always_comb begin
        byte_en = 4'b0000;
        wr_word = i_write_data;
        if (is_word) begin
            byte_en = 4'b1111;
            wr_word = i_write_data;
        end else if (is_half) begin
            byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{i_write_data[15:0]}};
        end else begin
            byte_en = 4'b0001 << byte_off;
            wr_word = {4{i_write_data[7:0]}};
        end
    end

    // Memory write port; contents are deliberately not touched by reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // MEM/WB register plus the load-return context. The raw word is read
    // synchronously; lane selection and extension happen on the registered
    // copy so the memory maps onto a plain synchronous-read RAM.
    logic [LEN-1:0] rd_word_q;
    logic [1:0]     rd_off_q;
    logic [1:0]     rd_size_q;
    logic           rd_uns_q;
    logic           rd_en_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ALU_result     <= '0;
            o_write_register <= '0;
            o_ctrl_wb_bus    <= '0;
            o_misaligned     <= 1'b0;
            rd_word_q        <= '0;
            rd_off_q         <= 2'b00;
            rd_size_q        <= 2'b00;
            rd_uns_q         <= 1'b0;
            rd_en_q          <= 1'b0;
        end else if (i_enable) begin
            o_ALU_result     <= i_ALU_result;
            o_write_register <= i_write_register;
            o_ctrl_wb_bus    <= i_ctrl_wb_bus;
            o_misaligned     <= misaligned;
            rd_word_q        <= mem[word_idx];
            rd_off_q         <= byte_off;
            rd_size_q        <= acc_size;
            rd_uns_q         <= load_unsigned;
            // A simultaneous store, or a misaligned access, returns zero.
            rd_en_q          <= mem_read & ~mem_write & ~misaligned;
        end
    end

    // Load lane select and extension, driven only by registered state.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte     = rd_word_q[{rd_off_q, 3'b000} +: 8];
        rd_half     = rd_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        o_read_data = '0;
        if (rd_en_q) begin
            if (rd_size_q[1]) begin
                o_read_data = rd_word_q;
            end else if (rd_size_q[0]) begin
                o_read_data = {{(LEN-16){~rd_uns_q & rd_half[15]}}, rd_half};
            end else begin
                o_read_data = {{(LEN-8){~rd_uns_q & rd_byte[7]}}, rd_byte};
            end
        end
    end

`ifdef MEM_DEBUG_PORT_EN
    // Second read-only port; free-running, independent of i_enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dbg_data <= '0;
        end else begin
            o_dbg_data <= mem[i_dbg_addr];
        end
    end
`else
    assign o_dbg_data = '0;

    logic unused_dbg;
    assign unused_dbg = ^i_dbg_addr;
`endif

    // Reserved control bits carry no meaning in this stage.
    logic unused_ctrl;
    assign unused_ctrl = ^i_ctrl_mem_bus[1:0];

endmodule

// File: tb/tb_seg_memory.sv
// -----------------------------------------------------------------------------
// tb_seg_memory -- self-checking bench for seg_memory.
//
// The reference model is a byte-addressed array: stores write 1/2/4 bytes at
// the (wrapped) byte address, loads assemble bytes little-endian and extend.
// For every clock edge the driver pushes the expected MEM/WB tuple into
// exp_q; the monitor pops one entry per edge and compares on the falling edge.
// Combinational outputs (branch decision, pass-throughs) are checked by the
// driver right after it applies the inputs.
// -----------------------------------------------------------------------------
module tb_seg_memory;

    localparam int LEN          = 32;
    localparam int NB_ADDR      = 5;
    localparam int NB_CTRL_WB   = 2;
    localparam int NB_CTRL_M    = 9;
    localparam int NB_DMEM_ADDR = 10;
    localparam int MEM_BYTES    = 4 * (2 ** NB_DMEM_ADDR);
    // {dbg_chk(1), dbg(32), read_data(32), alu(32), wreg(5), wb(2), mis(1)}
    localparam int W = 105;

    // ---------------- clock / reset / DUT ----------------
    logic                    i_clk;
    logic                    i_rst;
    logic                    i_enable;
    logic [LEN-1:0]          i_PC_branch;
    logic [LEN-1:0]          i_ALU_result;
    logic [LEN-1:0]          i_write_data;
    logic [NB_ADDR-1:0]      i_write_register;
    logic                    i_ALU_zero;
    logic [NB_CTRL_WB-1:0]   i_ctrl_wb_bus;
    logic [NB_CTRL_M-1:0]    i_ctrl_mem_bus;
    logic [LEN-1:0]          o_PC_branch;
    logic                    o_PC_src;
    logic [LEN-1:0]          o_rd_mem_forward;
    logic [LEN-1:0]          o_read_data;
    logic [LEN-1:0]          o_ALU_result;
    logic [NB_ADDR-1:0]      o_write_register;
    logic [NB_CTRL_WB-1:0]   o_ctrl_wb_bus;
    logic                    o_misaligned;
    logic [NB_DMEM_ADDR-1:0] i_dbg_addr;
    logic [LEN-1:0]          o_dbg_data;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    seg_memory #(
        .LEN(LEN), .NB_ADDR(NB_ADDR), .NB_CTRL_WB(NB_CTRL_WB),
        .NB_CTRL_M(NB_CTRL_M), .NB_DMEM_ADDR(NB_DMEM_ADDR)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .i_PC_branch(i_PC_branch), .i_ALU_result(i_ALU_result),
        .i_write_data(i_write_data), .i_write_register(i_write_register),
        .i_ALU_zero(i_ALU_zero), .i_ctrl_wb_bus(i_ctrl_wb_bus),
        .i_ctrl_mem_bus(i_ctrl_mem_bus), .o_PC_branch(o_PC_branch),
        .o_PC_src(o_PC_src), .o_rd_mem_forward(o_rd_mem_forward),
        .o_read_data(o_read_data), .o_ALU_result(o_ALU_result),
        .o_write_register(o_write_register), .o_ctrl_wb_bus(o_ctrl_wb_bus),
        .o_misaligned(o_misaligned), .i_dbg_addr(i_dbg_addr),
        .o_dbg_data(o_dbg_data)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    byte unsigned mem_b [MEM_BYTES];
    bit           known [2 ** NB_DMEM_ADDR];
    logic [71:0]  last_t = '0;
    logic [NB_DMEM_ADDR-1:0] dbg_cur = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] mb(input bit rd, input bit wr, input bit beq,
                                      input bit bne, input logic [1:0] sz, input bit uns);
        return {rd, wr, beq, bne, sz, uns, 2'b00};
    endfunction

    function automatic logic [31:0] model_word(input int wi);
        return {mem_b[4*wi+3], mem_b[4*wi+2], mem_b[4*wi+1], mem_b[4*wi]};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit rst, input bit en, input logic [31:0] pcb,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] wreg, input bit z, input logic [1:0] wb,
                        input logic [8:0] m);
        int          ba;
        int          nb;
        bit          rdq;
        bit          wrq;
        bit          mis;
        logic [31:0] rdv;
        logic [31:0] dbgv;
        bit          dchk;
        logic [71:0] t;

        i_rst = rst; i_enable = en; i_PC_branch = pcb; i_ALU_result = alu;
        i_write_data = wd; i_write_register = wreg; i_ALU_zero = z;
        i_ctrl_wb_bus = wb; i_ctrl_mem_bus = m; i_dbg_addr = dbg_cur;
        #1;
        check("pc_src", {31'd0, o_PC_src}, {31'd0, (m[6] & z) | (m[5] & ~z)});
        check("pc_branch", o_PC_branch, pcb);
        check("fwd", o_rd_mem_forward, alu);

        ba   = int'(alu & 32'hFFF);
        nb   = (m[4:3] == 2'b00) ? 1 : (m[4:3] == 2'b01) ? 2 : 4;
        rdq  = m[8];
        wrq  = m[7];
        mis  = (rdq || wrq) && (ba % nb != 0);
        rdv  = '0;
        dbgv = '0;
        dchk = 1'b1;
`ifdef MEM_DEBUG_PORT_EN
        if (!rst) begin
            dbgv = model_word(int'(dbg_cur));
            dchk = known[dbg_cur];
        end
`endif
        if (rst) begin
            t = '0;
        end else if (!en) begin
            t = last_t;
        end else begin
            if (rdq && !wrq && !mis) begin
                for (int k = 0; k < nb; k++) rdv |= 32'(mem_b[ba+k]) << (8*k);
                if (nb < 4 && !m[2] && rdv[8*nb-1]) rdv |= 32'hFFFF_FFFF << (8*nb);
            end
            t = {rdv, alu, wreg, wb, mis};
            if (wrq && !mis) begin
                for (int k = 0; k < nb; k++) mem_b[ba+k] = 8'((wd >> (8*k)) & 32'hFF);
                if (nb == 4) known[ba/4] = 1'b1;
            end
        end
        last_t = t;
        exp_q.push_back({dchk, dbgv, t});
        @(posedge i_clk);
        #1;
    endtask

    task automatic mem_op(input bit rd, input bit wr, input logic [1:0] sz,
                          input bit uns, input logic [31:0] addr, input logic [31:0] data);
        step(1'b0, 1'b1, $urandom, addr, data, 5'($urandom_range(0, 31)), 1'b0,
             2'($urandom_range(0, 3)), mb(rd, wr, 1'b0, 1'b0, sz, uns));
    endtask

    task automatic nop();
        step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 9'h000);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [W-1:0] e;
        forever begin
            @(posedge i_clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                @(negedge i_clk);
                check("misaligned", {31'd0, o_misaligned}, {31'd0, e[0]});
                check("ctrl_wb", {30'd0, o_ctrl_wb_bus}, {30'd0, e[2:1]});
                check("write_register", {27'd0, o_write_register}, {27'd0, e[7:3]});
                check("alu_result", o_ALU_result, e[39:8]);
                check("read_data", o_read_data, e[71:40]);
                if (e[104]) check("dbg_data", o_dbg_data, e[103:72]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        int op;
        logic [31:0] a;
        i_rst = 1'b1; i_enable = 1'b0; i_PC_branch = '0; i_ALU_result = '0;
        i_write_data = '0; i_write_register = '0; i_ALU_zero = 1'b0;
        i_ctrl_wb_bus = '0; i_ctrl_mem_bus = '0; i_dbg_addr = '0;
        foreach (mem_b[i]) mem_b[i] = 8'h00;
        foreach (known[i]) known[i] = 1'b0;

        step(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 9'h000);
        step(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 9'h000);

        // Bring the test region (words 0..15) to a known state.
        for (int w = 0; w < 16; w++) mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'(4*w), 32'h0);

        // Store word then load it back on the next cycle.
        mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);

        // Byte store and signed/unsigned byte loads.
        mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h4, 32'h0);
        mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_0080);
        mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0);
        mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0);

        // Halfword store/load, then a misaligned word store.
        mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h4, 32'h0);
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_ABCD);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0);
        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h2, 32'h5555_5555);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        mem_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h3, 32'h0);
        mem_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h8, 32'h0);

        // Branch resolution.
        step(1'b0, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 5'd1, 1'b1, 2'b10, mb(0, 0, 1, 0, 2'b00, 0));
        step(1'b0, 1'b1, 32'h0000_5678, 32'h0, 32'h0, 5'd2, 1'b1, 2'b01, mb(0, 0, 0, 1, 2'b00, 0));
        step(1'b0, 1'b1, 32'h0000_9ABC, 32'h0, 32'h0, 5'd3, 1'b0, 2'b11, mb(0, 0, 0, 1, 2'b00, 0));

        // Stalled store: no write, outputs hold.
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h9999_9999, 5'd7, 1'b0, 2'b11, mb(0, 1, 0, 0, 2'b11, 0));
        step(1'b0, 1'b0, 32'h0, 32'h0, 32'h9999_9999, 5'd7, 1'b0, 2'b11, mb(0, 1, 0, 0, 2'b11, 0));
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);

        // Reset in the middle of a load; reset also blocks a store.
        step(1'b1, 1'b1, 32'h0, 32'h10, 32'h0, 5'd9, 1'b0, 2'b11, mb(1, 0, 0, 0, 2'b11, 0));
        step(1'b1, 1'b1, 32'h0, 32'h14, 32'h7777_7777, 5'd9, 1'b0, 2'b11, mb(0, 1, 0, 0, 2'b11, 0));
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h14, 32'h0);

        // Address wrap, simultaneous read/write, debug port.
        mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'hFFFF_F024, 32'hCAFE_F00D);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h24, 32'h0);
        mem_op(1'b1, 1'b1, 2'b11, 1'b0, 32'h28, 32'h1357_9BDF);
        mem_op(1'b0, 1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678);
        dbg_cur = 10'd8;
        nop();
        nop();

        // Randomized traffic within the initialised region.
        for (int n = 0; n < 400; n++) begin
            op      = $urandom_range(0, 99);
            a       = {20'($urandom_range(0, 3)), 6'd0, 6'($urandom_range(0, 63))};
            dbg_cur = 10'($urandom_range(0, 15));
            if (op < 2) begin
                step(1'b1, 1'($urandom_range(0, 1)), $urandom, a, $urandom, 5'($urandom),
                     1'($urandom), 2'($urandom), 9'($urandom));
            end else begin
                step(1'b0, (op >= 10), $urandom, a, $urandom, 5'($urandom),
                     1'($urandom), 2'($urandom),
                     {1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      2'($urandom), 1'($urandom), 2'($urandom)});
            end
        end
        nop();

        repeat (3) @(negedge i_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
